input_conditioner: RTL and testbench
====================================

// Module: input_conditioner
// PURPOSE
//  Upstream front end for the 4-bit set/reset data register. Synchronises and
//  debounces raw switch inputs plus SET and CLEAR push-buttons.
//  Presents a clean data word on d_out, with a one-cycle d_valid strobe on each change.
//  Emits one-cycle set_pulse/clr_pulse on debounced button presses; these drive
//  the register's d, set and reset inputs directly.
// PARAMETERS
//  WIDTH            4   data switch channels
//  SYNC_STAGES      2   flops in each metastability chain (>=2)
//  DEBOUNCE_CYCLES  16  consecutive stable cycles required (board build: 500000)
//  CNT_W            localparam = $clog2(DEBOUNCE_CYCLES)+1, counter width
// PORTS
//  clk        in   1      system clock, all state on posedge
//  reset      in   1      synchronous, active-high
//  raw_in     in   WIDTH  asynchronous switch inputs
//  set_btn    in   1      asynchronous SET push-button, active-high
//  clr_btn    in   1      asynchronous CLEAR push-button, active-high
//  d_out      out  WIDTH  debounced data word
//  d_valid    out  1      1-cycle strobe: d_out changed this cycle
//  set_pulse  out  1      1-cycle strobe on debounced set_btn rising edge
//  clr_pulse  out  1      1-cycle strobe on debounced clr_btn rising edge
// BEHAVIOUR
//  - Reset (sync): all sync flops, stable values, counters, edge regs -> 0.
//    Outputs d_out=0, d_valid=0, set_pulse=0, clr_pulse=0 on the edge after reset.
//  - Each channel (WIDTH data + 2 buttons) is independent:
//    sync chain -> sync value s; registered stable value v; counter cnt.
//  - When s==v, cnt <= 0.
//  - When s!=v and cnt<DEBOUNCE_CYCLES-1, cnt <= cnt+1.
//  - When s!=v and cnt==DEBOUNCE_CYCLES-1, v <= s and cnt <= 0.
//  - Latency: raw level change held steady -> v updates SYNC_STAGES+DEBOUNCE_CYCLES
//    edges after the first edge that samples it.
//  - Glitch: any pulse shorter than DEBOUNCE_CYCLES synced cycles restarts cnt;
//    v does not change and no strobe is emitted.
//  - d_out = stable data v's, registered; d_valid=1 for exactly the cycle d_out
//    differs from its previous value. Several bits settling the same cycle
//    produce one strobe.
//  - set_pulse/clr_pulse = v & ~v_prev per button, one cycle, registered with v.
//    Held button -> exactly one pulse. Release -> no pulse.
//  - Simultaneous SET and CLEAR: both pulses are asserted in the same cycle; no
//    arbitration here (downstream register priority applies).
//  - Reset mid-count discards progress. A button held through reset gives one
//    set_pulse/clr_pulse SYNC_STAGES+DEBOUNCE_CYCLES edges after reset falls.
//  - Counter saturates logically at DEBOUNCE_CYCLES-1; it never wraps.
// STRUCTURE
//  - Shared constants header lab_defs.vh: DEFAULT_SYNC_STAGES, DEFAULT_DEBOUNCE
//    (sim and board values). No typedefs are required.
//  - Sub-module debounce_bit (params SYNC_STAGES, DEBOUNCE_CYCLES; ports clk,
//    reset, raw, stable, rise). Instantiated WIDTH+2 times via generate.
//  - Top level holds only d_out/d_valid change detection and output registers.
// TESTING  (SYNC_STAGES=2, DEBOUNCE_CYCLES=4)
//  1 reset held 3 cycles with raw_in=1111 -> all outputs 0 during and on release edge
//  2 raw_in 0000->1010 held -> d_out=1010 and d_valid=1 on edge 6 after change;
//    d_valid=0 next cycle
//  3 raw_in[0] high for 3 cycles then low -> d_out stays 0000, d_valid never 1
//  4 set_btn held 20 cycles -> set_pulse=1 exactly one cycle (edge 6);
//    release -> no further pulse
//  5 set_btn and clr_btn rise same cycle -> set_pulse and clr_pulse both 1 in the same cycle
//  6 raw_in=0001, reset pulsed 3 cycles after change -> d_out=0000; d_out=0001 on
//    edge 6 after reset release

Source files
------------

// File: rtl/input_conditioner_pkg.sv
`default_nettype none
// ============================================================================
// Module      : input_conditioner_pkg
// Description : Shared constants and helpers for the switch/button input
//               conditioner (default widths, sync depth, debounce lengths).
// Revision    : 1.0 - initial release
// ============================================================================
package input_conditioner_pkg;

  // Number of data switch channels presented on d_out.
  localparam int DEFAULT_WIDTH       = 4;

  // Flops in each metastability chain; two is the minimum safe depth.
  localparam int DEFAULT_SYNC_STAGES = 2;

  // Debounce lengths: short value for simulation, long value for the board.
  localparam int DEFAULT_DEBOUNCE    = 16;
  localparam int BOARD_DEBOUNCE      = 500000;

  // Push-buttons ride alongside the data switches as extra channels.
  localparam int NUM_BUTTONS         = 2;
  localparam int BTN_SET             = 0;
  localparam int BTN_CLR             = 1;

  // Counter width able to hold DEBOUNCE_CYCLES-1 with one bit of headroom.
  function automatic int cnt_width(input int cycles);
    return $clog2(cycles) + 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/input_conditioner_if.sv
`default_nettype none
// ============================================================================
// Module      : input_conditioner_if
// Description : Bundle of raw switch/button inputs and conditioned outputs.
//               master = the board/stimulus side, slave = the conditioner.
// Revision    : 1.0 - initial release
// ============================================================================
interface input_conditioner_if
  import input_conditioner_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) ();

  logic [WIDTH-1:0] raw_in;
  logic             set_btn;
  logic             clr_btn;
  logic [WIDTH-1:0] d_out;
  logic             d_valid;
  logic             set_pulse;
  logic             clr_pulse;

  modport master (
    output raw_in, set_btn, clr_btn,
    input  d_out, d_valid, set_pulse, clr_pulse
  );

  modport slave (
    input  raw_in, set_btn, clr_btn,
    output d_out, d_valid, set_pulse, clr_pulse
  );

endinterface
`default_nettype wire

// File: rtl/input_conditioner_debounce_bit.sv
`default_nettype none
// ============================================================================
// Module      : debounce_bit
// Description : One conditioned channel: synchroniser chain, stability
//               counter, registered stable level and a one-cycle rise flag
//               that asserts in the same cycle the stable level goes high.
// Revision    : 1.0 - initial release
// ============================================================================
module debounce_bit
  import input_conditioner_pkg::*;
#(
  parameter int SYNC_STAGES     = DEFAULT_SYNC_STAGES,
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE
) (
  input  wire logic clk,
  input  wire logic reset,
  input  wire logic raw,
  output logic      stable,
  output logic      rise
);

  localparam int             CNT_W   = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   synced;
  logic [CNT_W-1:0]       cnt;
  logic                   commit;

  assign synced = sync_q[SYNC_STAGES-1];

  // The synced level has disagreed with the stable level for the full
  // qualification window, so it is adopted this edge.
  assign commit = (synced != stable) && (cnt == CNT_MAX);

  // Metastability chain: raw enters at bit 0 and leaves at the top bit.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], raw};
    end
  end

  // Qualification counter, stable level and rising-edge strobe.
  always_ff @(posedge clk) begin
    if (reset) begin
      stable <= 1'b0;
      cnt    <= '0;
      rise   <= 1'b0;
    end else begin
      rise <= commit & synced;
      if (synced == stable) begin
        cnt <= '0;
      end else if (commit) begin
        stable <= synced;
        cnt    <= '0;
      end else begin
        // commit catches cnt==CNT_MAX first, so this never wraps.
        cnt <= cnt + CNT_ONE;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/input_conditioner.sv
`default_nettype none
// ============================================================================
// Module      : input_conditioner
// Description : Front end for the 4-bit set/reset data register. Debounces
//               WIDTH switch inputs plus SET/CLEAR buttons, presents the clean
//               data word with a change strobe, and one-cycle button pulses.
// Revision    : 1.0 - initial release
// ============================================================================
module input_conditioner
  import input_conditioner_pkg::*;
#(
  parameter int WIDTH           = DEFAULT_WIDTH,
  parameter int SYNC_STAGES     = DEFAULT_SYNC_STAGES,
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE
) (
  input  wire logic          clk,
  input  wire logic          reset,
  input_conditioner_if.slave bus
);

  localparam int CHANNELS = WIDTH + NUM_BUTTONS;

  logic [CHANNELS-1:0]    raw_all;
  logic [CHANNELS-1:0]    stable_all;
  logic [CHANNELS-1:0]    rise_all;
  logic [WIDTH-1:0]       d_prev;
  logic [WIDTH-1:0]       unused_data_rise;
  logic [NUM_BUTTONS-1:0] unused_btn_stable;

  // Channel map: data switches in the low bits, then SET, then CLEAR.
  assign raw_all = {bus.clr_btn, bus.set_btn, bus.raw_in};

  generate
    for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
      debounce_bit #(
        .SYNC_STAGES     (SYNC_STAGES),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
      ) u_debounce (
        .clk    (clk),
        .reset  (reset),
        .raw    (raw_all[i]),
        .stable (stable_all[i]),
        .rise   (rise_all[i])
      );
    end
  endgenerate

  // Previous data word; d_valid flags the cycle the word differs from it,
  // so several bits settling together still give a single strobe.
  always_ff @(posedge clk) begin
    if (reset) begin
      d_prev <= '0;
    end else begin
      d_prev <= stable_all[WIDTH-1:0];
    end
  end

  // Stable levels and rise flags are already flop outputs.
  assign bus.d_out     = stable_all[WIDTH-1:0];
  assign bus.d_valid   = (stable_all[WIDTH-1:0] != d_prev);
  assign bus.set_pulse = rise_all[WIDTH + BTN_SET];
  assign bus.clr_pulse = rise_all[WIDTH + BTN_CLR];

  // Data channels need no rise flag; buttons need no level output.
  assign unused_data_rise  = rise_all[WIDTH-1:0];
  assign unused_btn_stable = stable_all[CHANNELS-1:WIDTH];

endmodule
`default_nettype wire

// File: tb/tb_input_conditioner.sv
`default_nettype none
// ============================================================================
// Module      : tb_input_conditioner
// Description : Self-checking bench for input_conditioner: directed scenarios
//               then random switch/button/reset traffic against a
//               sample-window reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_input_conditioner;

  localparam int WIDTH = 4;
  localparam int SYNC  = 2;
  localparam int DEB   = 4;
  localparam int CH    = WIDTH + 2;

  logic clk;
  logic reset;
  int   compared = 0;
  int   mism     = 0;
  int   cyc      = 0;

  // Raw samples seen since the last reset, oldest first: {clr, set, raw_in}.
  logic [CH-1:0] hist[$];
  logic [CH-1:0] exp_v;
  logic          exp_valid;
  logic          exp_set;
  logic          exp_clr;

  input_conditioner_if #(.WIDTH(WIDTH)) bus ();

  input_conditioner #(
    .WIDTH           (WIDTH),
    .SYNC_STAGES     (SYNC),
    .DEBOUNCE_CYCLES (DEB)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // 10 time-unit clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    compared++;
    assert (got === want) else begin
      mism++;
      $error("FAIL %s cycle %0d: observed %0h expected %0h", tag, cyc, got, want);
    end
  endtask

  // Sample idx of the post-reset history; anything earlier reads as the
  // cleared synchroniser contents.
  function automatic logic [CH-1:0] samp(input int idx);
    if (idx < 0) return '0;
    return hist[idx];
  endfunction

  // Apply inputs, take one edge, advance the model, compare all outputs.
  task automatic step(input logic [3:0] r, input logic sb, input logic cb, input logic rs);
    logic [CH-1:0] nv;
    logic [CH-1:0] w;
    bit            all_diff;
    int            n;
    bus.raw_in  = r;
    bus.set_btn = sb;
    bus.clr_btn = cb;
    reset       = rs;
    @(posedge clk);
    cyc++;
    if (rs) begin
      hist.delete();
      exp_v     = '0;
      exp_valid = 1'b0;
      exp_set   = 1'b0;
      exp_clr   = 1'b0;
    end else begin
      hist.push_back({cb, sb, r});
      n  = hist.size();
      nv = exp_v;
      // A channel takes a new level when the DEB samples that have fully
      // crossed the SYNC-deep synchroniser all disagree with its level.
      for (int c = 0; c < CH; c++) begin
        all_diff = 1'b1;
        for (int j = 0; j < DEB; j++) begin
          w = samp(n - 1 - SYNC - j);
          if (w[c] == exp_v[c]) all_diff = 1'b0;
        end
        if (all_diff) nv[c] = ~exp_v[c];
      end
      exp_valid = (nv[3:0] != exp_v[3:0]);
      exp_set   = nv[4] & ~exp_v[4];
      exp_clr   = nv[5] & ~exp_v[5];
      exp_v     = nv;
      while (hist.size() > SYNC + DEB) void'(hist.pop_front());
    end
    #1;
    check("model_d_out",     32'(bus.d_out),     32'(exp_v[3:0]));
    check("model_d_valid",   32'(bus.d_valid),   32'(exp_valid));
    check("model_set_pulse", 32'(bus.set_pulse), 32'(exp_set));
    check("model_clr_pulse", 32'(bus.clr_pulse), 32'(exp_clr));
  endtask

  // Directed scenarios followed by random traffic.
  initial begin
    int         pulses;
    int         pulses_clr;
    int         at;
    int         seen;
    int         hold;
    logic [3:0] r;
    logic       sb;
    logic       cb;
    logic       rs;

    bus.raw_in  = '0;
    bus.set_btn = 1'b0;
    bus.clr_btn = 1'b0;
    reset       = 1'b1;
    exp_v       = '0;
    exp_valid   = 1'b0;
    exp_set     = 1'b0;
    exp_clr     = 1'b0;

    // Reset held three cycles with all switches high, then released.
    for (int i = 0; i < 3; i++) begin
      step(4'hF, 1'b0, 1'b0, 1'b1);
      check("t1_rst_d_out",   32'(bus.d_out), 32'(0));
      check("t1_rst_strobes", 32'({bus.d_valid, bus.set_pulse, bus.clr_pulse}), 32'(0));
    end
    step(4'hF, 1'b0, 1'b0, 1'b0);
    check("t1_release_d_out",   32'(bus.d_out), 32'(0));
    check("t1_release_strobes", 32'({bus.d_valid, bus.set_pulse, bus.clr_pulse}), 32'(0));
    repeat (8) step(4'h0, 1'b0, 1'b0, 1'b0);
    check("t1_short_high_ignored", 32'(bus.d_out), 32'(0));

    // Two bits change together: one strobe on edge 6.
    repeat (5) step(4'hA, 1'b0, 1'b0, 1'b0);
    check("t2_d_out_edge5", 32'(bus.d_out), 32'(0));
    step(4'hA, 1'b0, 1'b0, 1'b0);
    check("t2_d_out_edge6",   32'(bus.d_out),   32'(4'hA));
    check("t2_d_valid_edge6", 32'(bus.d_valid), 32'(1));
    step(4'hA, 1'b0, 1'b0, 1'b0);
    check("t2_d_valid_edge7", 32'(bus.d_valid), 32'(0));

    // Return to zero, then a DEB-1 cycle glitch on bit 0 is rejected.
    repeat (8) step(4'h0, 1'b0, 1'b0, 1'b0);
    check("t3_back_to_zero", 32'(bus.d_out), 32'(0));
    seen = 0;
    repeat (3) begin
      step(4'h1, 1'b0, 1'b0, 1'b0);
      if (bus.d_valid) seen++;
    end
    repeat (10) begin
      step(4'h0, 1'b0, 1'b0, 1'b0);
      if (bus.d_valid) seen++;
    end
    check("t3_glitch_d_out",   32'(bus.d_out), 32'(0));
    check("t3_glitch_strobes", 32'(seen),      32'(0));

    // SET held 20 cycles: exactly one pulse on edge 6, none on release.
    pulses = 0;
    at     = 0;
    for (int i = 1; i <= 20; i++) begin
      step(4'h0, 1'b1, 1'b0, 1'b0);
      if (bus.set_pulse) begin
        pulses++;
        at = i;
      end
    end
    check("t4_set_pulse_count", 32'(pulses), 32'(1));
    check("t4_set_pulse_edge",  32'(at),     32'(6));
    pulses = 0;
    repeat (12) begin
      step(4'h0, 1'b0, 1'b0, 1'b0);
      if (bus.set_pulse) pulses++;
    end
    check("t4_release_no_pulse", 32'(pulses), 32'(0));

    // SET and CLEAR together: both pulses in the same cycle.
    pulses     = 0;
    pulses_clr = 0;
    at         = 0;
    for (int i = 1; i <= 8; i++) begin
      step(4'h0, 1'b1, 1'b1, 1'b0);
      if (bus.set_pulse) pulses++;
      if (bus.clr_pulse) pulses_clr++;
      if (bus.set_pulse && bus.clr_pulse) at = i;
    end
    check("t5_set_count",  32'(pulses),     32'(1));
    check("t5_clr_count",  32'(pulses_clr), 32'(1));
    check("t5_joint_edge", 32'(at),         32'(6));
    repeat (8) step(4'h0, 1'b0, 1'b0, 1'b0);

    // Reset three cycles into a change discards the progress.
    repeat (3) step(4'h1, 1'b0, 1'b0, 1'b0);
    repeat (3) step(4'h1, 1'b0, 1'b0, 1'b1);
    check("t6_reset_d_out", 32'(bus.d_out), 32'(0));
    repeat (5) step(4'h1, 1'b0, 1'b0, 1'b0);
    check("t6_d_out_edge5", 32'(bus.d_out), 32'(0));
    step(4'h1, 1'b0, 1'b0, 1'b0);
    check("t6_d_out_edge6",   32'(bus.d_out),   32'(1));
    check("t6_d_valid_edge6", 32'(bus.d_valid), 32'(1));

    // A pulse exactly DEB cycles long is accepted, then released.
    seen = 0;
    repeat (4) begin
      step(4'h3, 1'b0, 1'b0, 1'b0);
      if (bus.d_valid) seen++;
    end
    repeat (12) begin
      step(4'h1, 1'b0, 1'b0, 1'b0);
      if (bus.d_valid) seen++;
    end
    check("t7_exact_window_strobes", 32'(seen),      32'(2));
    check("t7_exact_window_d_out",   32'(bus.d_out), 32'(1));

    // Random levels, hold lengths, button presses and occasional resets.
    for (int s = 0; s < 250; s++) begin
      r    = 4'($urandom);
      sb   = 1'($urandom);
      cb   = 1'($urandom);
      hold = $urandom_range(1, 7);
      rs   = ($urandom_range(0, 29) == 0);
      repeat (hold) step(r, sb, cb, rs);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mism);
    $finish;
  end

endmodule
`default_nettype wire
